// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master engine between several requesters.
// Grants one requester, starts the engine, waits for completion or timeout, returns the response.
module spi_arbiter #(
    parameter int req_count      = 4,
    parameter int word_width     = 8,
    parameter int SS_width       = 1,
    parameter int timeout_cycles = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [req_count-1:0]            req,
    input  logic [req_count*word_width-1:0] req_data,
    input  logic [req_count*SS_width-1:0]   req_ss,
    output logic [req_count-1:0]            grant,
    output logic [req_count-1:0]            done,
    output logic [word_width-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            spi_start,
    output logic [word_width-1:0]           spi_tx,
    output logic [SS_width-1:0]             spi_ss,
    input  logic                            spi_done,
    input  logic [word_width-1:0]           spi_rx
);

    localparam int PTR_W = $clog2(req_count);
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    localparam logic [PTR_W:0]         REQ_N = (PTR_W + 1)'(req_count);
    localparam logic [PTR_W-1:0]       LAST  = PTR_W'(req_count - 1);
    localparam logic [req_count-1:0]   ONE   = {{(req_count - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]       LIMIT = CNT_W'(timeout_cycles);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [PTR_W-1:0]        ptr_r, ptr_s;
    logic [PTR_W-1:0]        owner_r, owner_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [req_count-1:0]    grant_r, grant_s;
    logic [req_count-1:0]    done_r, done_s;
    logic [word_width-1:0]   rsp_data_r, rsp_data_s;
    logic                    rsp_err_r, rsp_err_s;
    logic                    spi_start_r, spi_start_s;
    logic [word_width-1:0]   spi_tx_r, spi_tx_s;
    logic [SS_width-1:0]     spi_ss_r, spi_ss_s;
    logic [PTR_W-1:0]        win_s;
    logic [PTR_W:0]          sum_s;
    logic                    found_s;
    logic                    timeout_s;

    assign timeout_s = (cnt_r == LIMIT);

    // Round-robin pick: first set request at or above ptr, wrapping modulo req_count.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_r;
        sum_s   = '0;
        for (int off = 0; off < req_count; off++) begin
            sum_s = {1'b0, ptr_r} + (PTR_W + 1)'(off);
            if (sum_s >= REQ_N) begin
                sum_s = sum_s - REQ_N;
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = sum_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: state_s = WAIT;
            WAIT: begin
                if (spi_done || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the datapath and outputs; spi_done takes priority over the timeout.
    always_comb begin
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        grant_s     = grant_r;
        done_s      = '0;
        rsp_data_s  = rsp_data_r;
        rsp_err_s   = rsp_err_r;
        spi_start_s = 1'b0;
        spi_tx_s    = spi_tx_r;
        spi_ss_s    = spi_ss_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    owner_s     = win_s;
                    grant_s     = ONE << win_s;
                    spi_start_s = 1'b1;
                    spi_tx_s    = req_data[int'(win_s) * word_width +: word_width];
                    spi_ss_s    = req_ss[int'(win_s) * SS_width +: SS_width];
                end else begin
                    grant_s = '0;
                end
            end
            START: cnt_s = '0;
            WAIT: begin
                if (spi_done) begin
                    rsp_data_s = spi_rx;
                    rsp_err_s  = 1'b0;
                    done_s     = grant_r;
                end else if (timeout_s) begin
                    rsp_data_s = '1;
                    rsp_err_s  = 1'b1;
                    done_s     = grant_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RESP: begin
                grant_s = '0;
                if (owner_r == LAST) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = owner_r + PTR_W'(1);
                end
            end
            default: grant_s = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= '0;
            owner_r     <= '0;
            cnt_r       <= '0;
            grant_r     <= '0;
            done_r      <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            spi_start_r <= 1'b0;
            spi_tx_r    <= '0;
            spi_ss_r    <= '0;
        end else begin
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            grant_r     <= grant_s;
            done_r      <= done_s;
            rsp_data_r  <= rsp_data_s;
            rsp_err_r   <= rsp_err_s;
            spi_start_r <= spi_start_s;
            spi_tx_r    <= spi_tx_s;
            spi_ss_r    <= spi_ss_s;
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign spi_start = spi_start_r;
    assign spi_tx    = spi_tx_r;
    assign spi_ss    = spi_ss_r;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: four requesters, timeout of 5 cycles,
// expected responses queued when the engine reply is driven and popped at done.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ss = 4'b0000;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_ss;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int ptr_m = 0;

    typedef struct packed {
        logic [3:0] done;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    spi_arbiter #(
        .req_count(4), .word_width(8), .SS_width(1), .timeout_cycles(5)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ss(req_ss),
        .grant(grant), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_ss(spi_ss),
        .spi_done(spi_done), .spi_rx(spi_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (spi_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called in the START cycle: pulse spi_done lat cycles later and queue the expected response.
    task automatic engine_reply(input int lat, input logic [7:0] rx, input logic [3:0] owner);
        step(lat);
        spi_done = 1'b1;
        spi_rx   = rx;
        exp_q.push_back('{done: owner, data: rx, err: 1'b0});
        step(1);
        spi_done = 1'b0;
        spi_rx   = 8'h00;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int off = 0; off < 4; off++) begin
            if (r[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        chk_cnt++;
        if ({grant, done, rsp_data, rsp_err, spi_start, spi_tx, spi_ss} !== 27'h0)
            $display("FAIL reset_outputs: got %h expected 0", {grant, done, rsp_data, rsp_err, spi_start, spi_tx, spi_ss});
        else pass_cnt++;
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_i;
        int prev_start;
        logic [3:0] g;
        prev_start = -1;
        req_data = 32'h44332211;
        req_ss   = 4'b1010;
        req      = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_start(20, ok);
            chk_cnt++;
            if (!ok) $display("FAIL rr_start_timeout: got no spi_start expected one (t=%0d)", t);
            else pass_cnt++;
            exp_i = rr_pick(req, ptr_m);
            g = 4'b0001 << exp_i;
            chk_cnt++;
            if (grant !== g) $display("FAIL rr_grant: got %b expected %b (t=%0d)", grant, g, t);
            else pass_cnt++;
            chk_cnt++;
            if (spi_tx !== req_data[exp_i*8 +: 8]) $display("FAIL rr_tx: got %h expected %h", spi_tx, req_data[exp_i*8 +: 8]);
            else pass_cnt++;
            if (prev_start >= 0) begin
                chk_cnt++;
                if (cyc - prev_start != 5) $display("FAIL rr_period: got %0d expected 5", cyc - prev_start);
                else pass_cnt++;
            end
            prev_start = cyc;
            engine_reply(2, 8'h80 + 8'(t), g);
            if (t == 4) req = 4'b0000;
            e = exp_q.pop_front();
            chk_cnt++;
            if ({done, rsp_data, rsp_err} !== e) $display("FAIL rr_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
            else pass_cnt++;
            ptr_m = (exp_i + 1) % 4;
            step(1);
            chk_cnt++;
            if ({done, grant} !== 8'h00) $display("FAIL rr_idle: got %h expected 00", {done, grant});
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        int c0;
        req_data[15:8] = 8'hA5;
        req_ss[1] = 1'b1;
        req = 4'b0010;
        c0 = cyc;
        step(1);
        chk_cnt++;
        if ({grant, spi_start, spi_tx, spi_ss} !== {4'b0010, 1'b1, 8'hA5, 1'b1})
            $display("FAIL single_start: got %h expected %h", {grant, spi_start, spi_tx, spi_ss}, {4'b0010, 1'b1, 8'hA5, 1'b1});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if (spi_start !== 1'b0) $display("FAIL single_start_pulse: got %b expected 0", spi_start);
        else pass_cnt++;
        engine_reply(3, 8'h3C, 4'b0010);
        req = 4'b0000;
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL single_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        chk_cnt++;
        if (cyc - c0 != 6) $display("FAIL single_latency: got %0d expected 6", cyc - c0);
        else pass_cnt++;
        ptr_m = 2;
        step(1);
        chk_cnt++;
        if ({done, grant} !== 8'h00) $display("FAIL single_idle: got %h expected 00", {done, grant});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        step(1);
        chk_cnt++;
        if ({grant, spi_start} !== {4'b0100, 1'b1}) $display("FAIL to_start: got %h expected %h", {grant, spi_start}, {4'b0100, 1'b1});
        else pass_cnt++;
        req = 4'b0000;
        exp_q.push_back('{done: 4'b0100, data: 8'hFF, err: 1'b1});
        step(6);
        chk_cnt++;
        if (done !== 4'b0000) $display("FAIL to_early: got %b expected 0000", done);
        else pass_cnt++;
        step(1);
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL to_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({done, grant} !== 8'h00) $display("FAIL to_idle: got %h expected 00", {done, grant});
        else pass_cnt++;
        ptr_m = 3;
    endtask

    task automatic test_simultaneous();
        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        step(1);
        chk_cnt++;
        if ({grant, spi_start, spi_tx} !== {4'b1000, 1'b1, 8'hC3}) $display("FAIL sim_start: got %h expected %h", {grant, spi_start, spi_tx}, {4'b1000, 1'b1, 8'hC3});
        else pass_cnt++;
        req = 4'b0000;
        engine_reply(6, 8'h96, 4'b1000);
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL sim_done_vs_timeout: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        ptr_m = 0;
        req = 4'b0001;
        step(1);
        chk_cnt++;
        if ({grant, spi_start, done} !== 9'h000) $display("FAIL sim_resp_req_ignored: got %h expected 000", {grant, spi_start, done});
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({grant, spi_start} !== {4'b0001, 1'b1}) $display("FAIL sim_resp_req_next: got %h expected %h", {grant, spi_start}, {4'b0001, 1'b1});
        else pass_cnt++;
        req = 4'b0000;
        engine_reply(2, 8'h5E, 4'b0001);
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL sim_second_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        ptr_m = 1;
        step(1);
    endtask

    task automatic test_drop();
        req = 4'b0100;
        step(1);
        chk_cnt++;
        if (grant !== 4'b0100) $display("FAIL drop_grant: got %b expected 0100", grant);
        else pass_cnt++;
        step(1);
        req = 4'b0000;
        engine_reply(2, 8'h1B, 4'b0100);
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL drop_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        ptr_m = 3;
        step(1);
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        req = 4'b0010;
        step(1);
        chk_cnt++;
        if (grant !== 4'b0010) $display("FAIL rmid_grant: got %b expected 0010", grant);
        else pass_cnt++;
        step(2);
        rst = 1'b1;
        spi_done = 1'b1;
        #1;
        chk_cnt++;
        if ({grant, done, rsp_data, rsp_err, spi_start, spi_tx, spi_ss} !== 27'h0)
            $display("FAIL rmid_async: got %h expected 0", {grant, done, rsp_data, rsp_err, spi_start, spi_tx, spi_ss});
        else pass_cnt++;
        step(1);
        spi_done = 1'b0;
        rst = 1'b0;
        ptr_m = 0;
        req = 4'b1000;
        step(1);
        g = 4'b0001 << rr_pick(req, ptr_m);
        chk_cnt++;
        if ({grant, spi_start} !== {g, 1'b1}) $display("FAIL rmid_regrant: got %h expected %h", {grant, spi_start}, {g, 1'b1});
        else pass_cnt++;
        req = 4'b0000;
        engine_reply(2, 8'h77, g);
        e = exp_q.pop_front();
        chk_cnt++;
        if ({done, rsp_data, rsp_err} !== e) $display("FAIL rmid_done: got %h expected %h", {done, rsp_data, rsp_err}, e);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({done, grant} !== 8'h00) $display("FAIL rmid_idle: got %h expected 00", {done, grant});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_simultaneous();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master engine between `req_count` requesters. It latches the winning requester's transmit word and slave-select code, then issues a single-cycle start to the engine. It waits for the engine's completion or a timeout, and returns the received word with a one-cycle `done` pulse. It sits between the peripheral clients and the SPI engine in the I/O subsystem.

## Interface
Parameters:
- `req_count`, 4: number of requesters, 2..16.
- `word_width`, 8: SPI transfer word width.
- `SS_width`, 1: slave-select code width.
- `timeout_cycles`, 255: maximum WAIT cycles before abort, 1..65535.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, req_count: per-requester transfer request (level).
- `req_data`, input, req_count*word_width: TX word of requester i at bits [i*word_width +: word_width].
- `req_ss`, input, req_count*SS_width: slave-select code of requester i at bits [i*SS_width +: SS_width].
- `grant`, output, req_count: one-hot; marks the owner of the current transaction.
- `done`, output, req_count: one-cycle completion pulse to the owner.
- `rsp_data`, output, word_width: received word; valid only while `done` is nonzero.
- `rsp_err`, output, 1: timeout flag; valid only while `done` is nonzero.
- `spi_start`, output, 1: one-cycle start strobe to the engine.
- `spi_tx`, output, word_width: TX word to the engine.
- `spi_ss`, output, SS_width: slave-select code to the engine.
- `spi_done`, input, 1: engine completion strobe.
- `spi_rx`, input, word_width: engine RX word; valid while `spi_done` is 1.

## Operation
- States are IDLE, START, WAIT and RESP. All outputs are registered.
- **IDLE:**
  - If `req` is nonzero, select the lowest index i at or above `ptr` (wrapping modulo req_count) with `req[i]` set.
  - Latch i, `req_data[i]` and `req_ss[i]`, set `grant[i]`, then go to START.
  - The `req` inputs are sampled only in IDLE.
- **START:**
  - `spi_start` is 1 for exactly this cycle.
  - `spi_tx` and `spi_ss` carry the latched values and stay stable until the transaction leaves RESP.
  - Clear the timeout counter and go to WAIT.
- **WAIT:**
  - If `spi_done` is 1, latch `spi_rx` into `rsp_data`, clear `rsp_err` and go to RESP.
  - Otherwise, when the counter reaches timeout_cycles, set `rsp_data` to all ones and `rsp_err` to 1, then go to RESP.
  - Otherwise, increment the counter.
  - If `spi_done` and the timeout occur in the same cycle, `spi_done` wins and `rsp_err` is 0.
- **RESP:**
  - `done[i]` is 1 for this cycle only.
  - Set `ptr` to (i+1) mod req_count, clear `grant`, then go to IDLE.
- `spi_done` is ignored in IDLE, START and RESP.
- A requester dropping `req` mid-transaction does not abort the transfer; it still completes and `done` still pulses.
- A requester must deassert `req` on the clock edge where it sees `done`, unless it wants another transfer. A request still high in the following IDLE cycle is treated as a new request.
- `ptr` width is clog2(req_count); the timeout counter width is clog2(timeout_cycles+1).

## Timing
- **Reset values:** state IDLE, `ptr` 0, and `grant`, `done`, `rsp_data`, `rsp_err`, `spi_start`, `spi_tx`, `spi_ss` all 0. Reset takes effect immediately and asynchronously, including mid-transaction.
- **Transaction timeline** (`req` seen in IDLE at cycle 0):
  - Cycle 1: `grant` and `spi_start` are 1.
  - Cycle 2 onward: WAIT.
  - If `spi_done` arrives at cycle k ≥ 2: `done` and `rsp_data` appear at k+1, and IDLE resumes at k+2.
- **Latency bounds:**
  - Minimum from `req` to `done` is 3 cycles.
  - On timeout, `done` appears timeout_cycles+2 cycles after START.
- **Back-to-back transfers:** minimum gap is one IDLE cycle between transactions. With two or more requesters saturated, throughput is one transfer per (engine latency + 3) cycles.
- `grant` is one-hot or zero at all times. `done` is never nonzero in two consecutive cycles.

## Test plan
- **Single request:** `req`=0010, `req_data[1]`=0xA5, `req_ss[1]`=1, engine returns `spi_rx`=0x3C on `spi_done` 4 cycles after start. Expected: `spi_start` pulses once with `spi_tx`=0xA5 and `spi_ss`=1, `grant`=0010, then `done`=0010 with `rsp_data`=0x3C and `rsp_err`=0.
- **Round robin:** all four requesters hold `req`=1111 continuously, reasserting after each `done`. Expected grant order is 0,1,2,3,0, with no requester granted twice before the others.
- **Timeout:** `timeout_cycles`=5 and `spi_done` is never asserted. Expected: `done` appears 7 cycles after START with `rsp_data`=0xFF and `rsp_err`=1, and the arbiter returns to IDLE.
- **Simultaneous events:**
  - `spi_done` arriving on the same cycle the counter reaches 5: expected `rsp_err`=0 and `rsp_data` equal to `spi_rx`.
  - `req` arriving on the RESP cycle: expected to be ignored until the following IDLE cycle.
- **Request dropped mid-transfer:** `req[2]` is deasserted during WAIT. Expected: the transfer still completes and `done[2]` still pulses.
- **Reset mid-transfer:** `rst` is asserted during WAIT. Expected: all outputs are 0 immediately. After release, `req`=1000 is granted to index 3 (`ptr` was reset to 0, so 3 is the first set index found).
